// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A request is
// granted combinationally in IDLE; the winner's mode/operands are registered
// onto ALU_MODE/ALU_A/ALU_B for one EXEC cycle, the ALU result and E/Z flags
// are captured at the end of EXEC, and the owner sees a one-cycle DONE pulse.
// Undefined modes (19..31) never reach the ALU: they go straight to DONE with
// ERR set and a zero result.
//
// Optional feature macro: ALU_ARB_RR_EN
//   defined   -> round-robin between simultaneous requesters
//   undefined -> fixed priority, requester 0 wins ties
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   REQ0/1, MODE0/1          request and 5-bit mode per requester
//   A0/B0, A1/B1             8-bit operands per requester
//   GNT0/1                   combinational grant (operands sampled this cycle)
//   DONE0/1                  one-cycle result-valid pulse to the owner
//   RDATA, RE, RZ, ERR       registered result, flags, rejected-mode flag
//   BUSY                     high whenever not IDLE
//   ALU_MODE, ALU_A, ALU_B   registered drive to the ALU
//   ALU_DATA, ALU_E, ALU_Z   ALU outputs
// -----------------------------------------------------------------------------
module alu_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [4:0] MODE0,
    input  logic [4:0] MODE1,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] RDATA,
    output logic       RE,
    output logic       RZ,
    output logic       ERR,
    output logic       BUSY,
    output logic [4:0] ALU_MODE,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    input  logic [7:0] ALU_DATA,
    input  logic       ALU_E,
    input  logic       ALU_Z
);

    localparam logic [4:0] MODE_MOV = 5'd8;
    localparam logic [4:0] MODE_MAX = 5'd18;
    localparam logic [4:0] MODE_CLE = 5'd17;
    localparam logic [4:0] MODE_CLZ = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [7:0] rdata_q, rdata_d;
    logic       re_q, re_d;
    logic       rz_q, rz_d;
    logic       err_q, err_d;
    logic [4:0] alu_mode_q, alu_mode_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;

    logic       req_any;
    logic       win;      // 0: requester 0 wins, 1: requester 1 wins
    logic       grant;
    logic [4:0] sel_mode;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    assign req_any = REQ0 | REQ1;
    // Reset overrides any request presented in the same cycle.
    assign grant   = (state_q == S_IDLE) && req_any && !RST;

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign win    = REQ0 ? (REQ1 ? ~last_q : 1'b0) : 1'b1;
    assign last_d = grant ? win : last_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = ~REQ0;
`endif

    assign sel_mode = win ? MODE1 : MODE0;
    assign sel_a    = win ? A1    : A0;
    assign sel_b    = win ? B1    : B0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rdata_d    = rdata_q;
        re_d       = re_q;
        rz_d       = rz_q;
        err_d      = err_q;
        alu_mode_d = alu_mode_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    owner_d = win;
                    if (sel_mode <= MODE_MAX) begin
                        alu_mode_d = sel_mode;
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        state_d    = S_EXEC;
                    end else begin
                        // Rejected mode: ALU keeps its idle MOV/0/0 drive.
                        rdata_d = 8'h00;
                        re_d    = 1'b0;
                        rz_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                // CLE/CLZ leave ALU data undefined, so the result is forced to 0.
                if ((alu_mode_q == MODE_CLE) || (alu_mode_q == MODE_CLZ)) begin
                    rdata_d = 8'h00;
                end else begin
                    rdata_d = ALU_DATA;
                end
                re_d       = ALU_E;
                rz_d       = ALU_Z;
                err_d      = 1'b0;
                alu_mode_d = MODE_MOV;
                alu_a_d    = 8'h00;
                alu_b_d    = 8'h00;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            rdata_q    <= 8'h00;
            re_q       <= 1'b0;
            rz_q       <= 1'b0;
            err_q      <= 1'b0;
            alu_mode_q <= MODE_MOV;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rdata_q    <= rdata_d;
            re_q       <= re_d;
            rz_q       <= rz_d;
            err_q      <= err_d;
            alu_mode_q <= alu_mode_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
        end
    end

    assign GNT0     = grant && !win;
    assign GNT1     = grant &&  win;
    assign DONE0    = (state_q == S_DONE) && !owner_q;
    assign DONE1    = (state_q == S_DONE) &&  owner_q;
    assign BUSY     = (state_q != S_IDLE);
    assign RDATA    = rdata_q;
    assign RE       = re_q;
    assign RZ       = rz_q;
    assign ERR      = err_q;
    assign ALU_MODE = alu_mode_q;
    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1;
    logic [4:0] MODE0, MODE1;
    logic [7:0] A0, B0, A1, B1;
    logic       GNT0, GNT1, DONE0, DONE1;
    logic [7:0] RDATA;
    logic       RE, RZ, ERR, BUSY;
    logic [4:0] ALU_MODE;
    logic [7:0] ALU_A, ALU_B;
    logic [7:0] ALU_DATA;
    logic       ALU_E, ALU_Z;

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
        .MODE0(MODE0), .MODE1(MODE1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RDATA(RDATA), .RE(RE), .RZ(RZ), .ERR(ERR), .BUSY(BUSY),
        .ALU_MODE(ALU_MODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_DATA(ALU_DATA), .ALU_E(ALU_E), .ALU_Z(ALU_Z)
    );

    // Stand-in ALU: returns {E, Z, raw data}. 4=INC, 5=NOT, 8=MOV, 15=ADD, 16=SUB.
    function automatic logic [9:0] alu_fn(input logic [4:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (m)
            5'd4:    r = a + 8'd1;
            5'd5:    r = ~a;
            5'd8:    r = a;
            5'd15:   r = a + b;
            5'd16:   r = a - b;
            default: r = a ^ b ^ {3'b000, m};
        endcase
        return {(a == b), (r == 8'h00), r};
    endfunction

    logic [9:0] alu_now;
    assign alu_now  = alu_fn(ALU_MODE, ALU_A, ALU_B);
    // Data is garbage for CLE/CLZ so the forced-zero result is observable.
    assign ALU_DATA = (ALU_MODE == 5'd17 || ALU_MODE == 5'd18) ? 8'hA5 : alu_now[7:0];
    assign ALU_E    = alu_now[9];
    assign ALU_Z    = alu_now[8];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an accepted request occupies the block until
    // free_at; its result appears at done_cyc, ALU drive is visible at alu_cyc.
    int         cyc = 0;
    int         free_at = 0;
    bit         pend = 0;
    bit         p_valid, p_owner;
    int         alu_cyc, done_cyc;
    logic [4:0] p_mode;
    logic [7:0] p_a, p_b, p_rdata;
    logic       p_re, p_rz, p_err;
    logic [7:0] h_rdata = 8'h00;
    logic       h_re = 0, h_rz = 0, h_err = 0;
    bit         m_last = 1;

    logic       s_gnt0, s_gnt1, s_done0, s_done1, s_busy, s_re, s_rz, s_err;
    logic [7:0] s_rdata, s_alu_a, s_alu_b;
    logic [4:0] s_alu_mode;

    task automatic step(input logic rst, input logic r0, input logic r1,
                        input logic [4:0] m0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [4:0] m1, input logic [7:0] a1, input logic [7:0] b1);
        bit         take, w, e_done;
        logic [4:0] e_mode;
        logic [7:0] e_a, e_b, wa, wb;
        logic [4:0] wm;
        logic [9:0] f;
        RST = rst; REQ0 = r0; REQ1 = r1;
        MODE0 = m0; A0 = a0; B0 = b0; MODE1 = m1; A1 = a1; B1 = b1;
        @(negedge CLK);
        take = !rst && (cyc >= free_at) && (r0 || r1);
`ifdef ALU_ARB_RR_EN
        w = (r0 && r1) ? !m_last : !r0;
`else
        w = !r0;
`endif
        e_done = pend && (cyc == done_cyc);
        if (e_done) begin
            h_rdata = p_rdata; h_re = p_re; h_rz = p_rz; h_err = p_err;
        end
        if (pend && p_valid && cyc == alu_cyc) begin
            e_mode = p_mode; e_a = p_a; e_b = p_b;
        end else begin
            e_mode = 5'd8; e_a = 8'h00; e_b = 8'h00;
        end
        s_gnt0 = GNT0; s_gnt1 = GNT1; s_done0 = DONE0; s_done1 = DONE1;
        s_busy = BUSY; s_rdata = RDATA; s_re = RE; s_rz = RZ; s_err = ERR;
        s_alu_mode = ALU_MODE; s_alu_a = ALU_A; s_alu_b = ALU_B;
        chk("gnt0", s_gnt0, take && !w);
        chk("gnt1", s_gnt1, take && w);
        chk("done0", s_done0, e_done && !p_owner);
        chk("done1", s_done1, e_done && p_owner);
        chk("busy", s_busy, cyc < free_at);
        chk("alu_mode", s_alu_mode, e_mode);
        chk("alu_a", s_alu_a, e_a);
        chk("alu_b", s_alu_b, e_b);
        chk("rdata", s_rdata, h_rdata);
        chk("flags_re_rz_err", {s_re, s_rz, s_err}, {h_re, h_rz, h_err});
        if (e_done) pend = 0;
        if (rst) begin
            pend = 0; free_at = cyc + 1; m_last = 1;
            h_rdata = 8'h00; h_re = 0; h_rz = 0; h_err = 0;
        end else if (take) begin
            wm = w ? m1 : m0; wa = w ? a1 : a0; wb = w ? b1 : b0;
            pend = 1; p_owner = w; m_last = w;
            p_valid = (wm <= 5'd18);
            p_mode = wm; p_a = wa; p_b = wb;
            if (p_valid) begin
                f = alu_fn(wm, wa, wb);
                p_rdata = (wm == 5'd17 || wm == 5'd18) ? 8'h00 : f[7:0];
                p_re = f[9]; p_rz = f[8]; p_err = 0;
                alu_cyc = cyc + 1; done_cyc = cyc + 2; free_at = cyc + 3;
            end else begin
                p_rdata = 8'h00; p_re = 0; p_rz = 0; p_err = 1;
                done_cyc = cyc + 1; free_at = cyc + 2;
            end
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic rst);
        step(rst, 0, 0, 5'd0, 8'h00, 8'h00, 5'd0, 8'h00, 8'h00);
    endtask

    typedef struct {
        logic       r0, r1;
        logic [4:0] m0; logic [7:0] a0, b0;
        logic [4:0] m1; logic [7:0] a1, b1;
        logic       owner;
        logic [7:0] rdata;
        logic       re, rz, err;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, k;
        bit got;
        RST = 1; REQ0 = 0; REQ1 = 0; MODE0 = 0; MODE1 = 0;
        A0 = 0; B0 = 0; A1 = 0; B1 = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 0;

        // Reset state
        idle(0);
        chk("reset_alu_mode", s_alu_mode, 5'd8);
        chk("reset_outputs", {s_gnt0, s_gnt1, s_done0, s_done1, s_busy, s_re, s_rz, s_err, s_rdata}, 16'h0000);

        vecs[0]  = '{1, 0, 5'd15, 8'h12, 8'h34, 5'd0,  8'h00, 8'h00, 0, 8'h46, 0, 0, 0, 2};
        vecs[1]  = '{0, 1, 5'd0,  8'h00, 8'h00, 5'd16, 8'h55, 8'h55, 1, 8'h00, 1, 1, 0, 2};
        vecs[2]  = '{1, 0, 5'd25, 8'h11, 8'h22, 5'd0,  8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1};
        vecs[3]  = '{1, 0, 5'd8,  8'h3C, 8'h00, 5'd0,  8'h00, 8'h00, 0, 8'h3C, 0, 0, 0, 2};
        vecs[4]  = '{1, 0, 5'd17, 8'h80, 8'h00, 5'd0,  8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 2};
        vecs[5]  = '{1, 0, 5'd18, 8'h12, 8'h12, 5'd0,  8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 2};
        vecs[6]  = '{0, 1, 5'd0,  8'h00, 8'h00, 5'd4,  8'hFF, 8'h00, 1, 8'h00, 0, 1, 0, 2};
        vecs[7]  = '{1, 0, 5'd5,  8'h0F, 8'h00, 5'd0,  8'h00, 8'h00, 0, 8'hF0, 0, 0, 0, 2};
        vecs[8]  = '{0, 1, 5'd0,  8'h00, 8'h00, 5'd19, 8'h01, 8'h01, 1, 8'h00, 0, 0, 1, 1};
        vecs[9]  = '{1, 1, 5'd15, 8'h01, 8'h02, 5'd16, 8'h09, 8'h03, 0, 8'h03, 0, 0, 0, 2};
`ifdef ALU_ARB_RR_EN
        vecs[10] = '{1, 1, 5'd15, 8'h01, 8'h02, 5'd16, 8'h09, 8'h03, 1, 8'h06, 0, 0, 0, 2};
`else
        vecs[10] = '{1, 1, 5'd15, 8'h01, 8'h02, 5'd16, 8'h09, 8'h03, 0, 8'h03, 0, 0, 0, 2};
`endif

        for (int i = 0; i < 11; i++) begin
            step(0, vecs[i].r0, vecs[i].r1, vecs[i].m0, vecs[i].a0, vecs[i].b0,
                 vecs[i].m1, vecs[i].a1, vecs[i].b1);
            chk($sformatf("vec%0d_gnt", i), {s_gnt1, s_gnt0}, vecs[i].owner ? 2'b10 : 2'b01);
            got = 0; k = 0;
            for (int c = 1; c <= 4 && !got; c++) begin
                idle(0);
                if (s_done0 || s_done1) begin got = 1; k = c; end
            end
            chk($sformatf("vec%0d_latency", i), k, vecs[i].lat);
            chk($sformatf("vec%0d_owner", i), {s_done1, s_done0}, vecs[i].owner ? 2'b10 : 2'b01);
            chk($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_re_rz_err", i), {s_re, s_rz, s_err}, {vecs[i].re, vecs[i].rz, vecs[i].err});
        end

        // Both requesting continuously: INC 0xFF on port 0, NOT 0x0F on port 1
        n0 = 0; n1 = 0;
        for (int c = 0; c < 12; c++) begin
            step(0, 1, 1, 5'd4, 8'hFF, 8'h00, 5'd5, 8'h0F, 8'h00);
            if (s_gnt0) n0++;
            if (s_gnt1) n1++;
            if (s_done0) chk("cont_done0_rdata", s_rdata, 8'h00);
            if (s_done1) chk("cont_done1_rdata", s_rdata, 8'hF0);
        end
`ifdef ALU_ARB_RR_EN
        chk("cont_grants", {n0[7:0], n1[7:0]}, {8'd2, 8'd2});
`else
        chk("cont_grants", {n0[7:0], n1[7:0]}, {8'd4, 8'd0});
`endif
        repeat (3) idle(0);

        // Reset during EXEC of an ADD drops the operation
        step(0, 1, 0, 5'd15, 8'h12, 8'h34, 5'd0, 8'h00, 8'h00);
        chk("rst_seq_gnt0", s_gnt0, 1'b1);
        step(1, 0, 0, 5'd0, 8'h00, 8'h00, 5'd0, 8'h00, 8'h00);
        chk("rst_seq_exec_alu_mode", s_alu_mode, 5'd15);
        step(0, 1, 0, 5'd15, 8'h01, 8'h01, 5'd0, 8'h00, 8'h00);
        chk("rst_seq_no_done", {s_done0, s_done1, s_busy}, 3'b000);
        chk("rst_seq_reset_vals", {s_alu_mode, s_alu_a, s_alu_b, s_rdata, s_err}, {5'd8, 24'h000000, 1'b0});
        chk("rst_seq_regrant", s_gnt0, 1'b1);
        repeat (3) idle(0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom),
                 5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
